cv32e40p_perm_fault_detector_ft: RTL and testbench
==================================================

// Module: cv32e40p_perm_fault_detector_ft
// PURPOSE
// - Upstream of the FT dispatcher: turns per-replica voter mismatch reports into sticky
//   permanent-fault vectors. These vectors drive the dispatcher's permanent_faulty_alu_i[3:0]
//   and permanent_faulty_mult_i[2:0] inputs.
// - One saturating error counter per ALU replica (4) and per MULT replica (3).
// - A replica is declared permanently faulty when its counter reaches THRESHOLD.
// PARAMETERS
// - THRESHOLD  default 4                          mismatches needed to flag a replica; legal 1..255
// - CNT_W      default $clog2(THRESHOLD+1)        counter width; derived, do not override
// PORTS
// - clk                     in   1  core clock
// - rst                     in   1  synchronous, active-high reset
// - clear_i                 in   1  SW/debug clear of all counters and flags
// - alu_valid_i             in   1  an ALU op was voted this cycle
// - alu_active_i            in   4  replicas that executed the op (dispatcher clock-gate vector)
// - alu_mismatch_i          in   4  voter: replica k disagreed with the majority
// - mult_valid_i            in   1  a MULT op was voted this cycle
// - mult_active_i           in   3  MULT replicas that executed the op
// - mult_mismatch_i         in   3  voter: MULT replica k disagreed
// - permanent_faulty_alu_o  out  4  sticky per-ALU fault flags, to the dispatcher
// - permanent_faulty_mult_o out  3  sticky per-MULT fault flags, to the dispatcher
// - fault_event_o           out  1  1-cycle pulse when any flag goes 0->1
// - alu_err_cnt_o           out  4*CNT_W  packed ALU counters, observability; ALU k at [k*CNT_W +: CNT_W]
// BEHAVIOUR
// - Reset: all counters, both fault vectors and fault_event_o are 0.
// - All state is registered; outputs come straight from flops.
// - Replica k update is qualified: upd = valid & active[k] & ~faulty[k]. Inactive or already
//   flagged replicas hold their count; their mismatch bit is ignored.
// - upd & mismatch[k]: cnt <= min(cnt+1, THRESHOLD).
//   - If cnt+1 == THRESHOLD, faulty[k] <= 1 on the same edge.
//   - So a mismatch in cycle n makes the flag visible in cycle n+1.
// - upd & ~mismatch[k]: behaviour is set by FT_PERM_FAULT_DECAY_EN (see CONFIGURATION).
// - Several replicas may mismatch in one cycle; each is counted independently. No priority.
// - alu_valid_i and mult_valid_i may both be high in a cycle; the two banks are fully independent.
// - Flags are sticky. Only rst or clear_i return them to 0.
//   - clear_i zeroes every counter and flag on the next edge.
//   - clear_i has priority over a simultaneous mismatch; that mismatch is dropped.
// - fault_event_o = |(next_faulty & ~faulty), registered. It is high for exactly one cycle per
//   set event, even if several bits set together. It is never asserted on clear.
// - All replicas flagged (4'b1111 / 3'b111) is legal. It is held; the dispatcher reports total defect.
// - THRESHOLD == 1: the first qualified mismatch flags the replica.
// - The counter never exceeds THRESHOLD and never wraps.
// CONFIGURATION
// - `define FT_PERM_FAULT_DECAY_EN (leaky counters):
//   - upd & ~mismatch[k] gives cnt <= max(cnt-1, 0).
//   - Isolated transient upsets are forgiven; only clustered errors reach THRESHOLD.
// - Without the macro:
//   - A matching result leaves cnt unchanged; counters only grow.
//   - THRESHOLD cumulative mismatches flag the replica.
// TESTING
// - rst=1 for 2 cycles, all inputs random -> every output 0, all counters 0.
// - THRESHOLD=4: 4 ALU ops, active=4'b0111, mismatch=4'b0010 each
//   -> permanent_faulty_alu_o=4'b0010 in the cycle after the 4th op.
//   -> fault_event_o pulses once.
//   -> ALU1 counter stays at 4 on further mismatches.
// - Mismatch on ALU3 while alu_active_i[3]=0 -> counter 3 unchanged.
//   Same for MULT2 with mult_valid_i=0.
// - DECAY_EN: sequence mismatch,match,mismatch,match on ALU0 -> cnt 1,0,1,0, never flagged.
//   No DECAY: the same sequence -> cnt 1,1,2,2.
// - Simultaneous: mismatch=4'b0011 with both counters at 3 -> both flags set the same edge,
//   a single-cycle fault_event_o. Then clear_i with a mismatch in the same cycle -> all 0 next cycle.
// - Drive all 3 MULT replicas to threshold -> permanent_faulty_mult_o=3'b111, held until clear_i.

Source files
------------

// File: rtl/cv32e40p_perm_fault_detector_ft_if.sv
// cv32e40p_perm_fault_detector_ft_if: voter-report and fault-flag bundle between the voters, the detector and its observers.
//   master: drives clear_i, alu/mult valid, active and mismatch vectors; observes the flags, event and counters
//   slave:  the detector side, with directions reversed
//   CNT_W:  per-counter width; must equal the detector's derived CNT_W
interface cv32e40p_perm_fault_detector_ft_if #(
    parameter int unsigned CNT_W = 3
);
    logic               clear_i;
    logic               alu_valid_i;
    logic [3:0]         alu_active_i;
    logic [3:0]         alu_mismatch_i;
    logic               mult_valid_i;
    logic [2:0]         mult_active_i;
    logic [2:0]         mult_mismatch_i;
    logic [3:0]         permanent_faulty_alu_o;
    logic [2:0]         permanent_faulty_mult_o;
    logic               fault_event_o;
    logic [4*CNT_W-1:0] alu_err_cnt_o;

    modport master (
        output clear_i, alu_valid_i, alu_active_i, alu_mismatch_i,
               mult_valid_i, mult_active_i, mult_mismatch_i,
        input  permanent_faulty_alu_o, permanent_faulty_mult_o, fault_event_o, alu_err_cnt_o
    );

    modport slave (
        input  clear_i, alu_valid_i, alu_active_i, alu_mismatch_i,
               mult_valid_i, mult_active_i, mult_mismatch_i,
        output permanent_faulty_alu_o, permanent_faulty_mult_o, fault_event_o, alu_err_cnt_o
    );
endinterface

// File: rtl/cv32e40p_perm_fault_detector_ft.sv
// cv32e40p_perm_fault_detector_ft: saturating per-replica mismatch counters that raise sticky permanent-fault flags.
//   clk, rst: clock and synchronous active-high reset
//   bus (slave): clear_i, alu/mult valid+active+mismatch in; fault vectors, fault_event_o, packed ALU counters out
//   THRESHOLD: mismatches needed to flag a replica (1..255)
//   FT_PERM_FAULT_DECAY_EN: when defined, a matching result decrements the counter (leaky counters)
module cv32e40p_perm_fault_detector_ft #(
    parameter int unsigned THRESHOLD = 4,
    localparam int unsigned CNT_W = $clog2(THRESHOLD + 1)
) (
    input logic clk,
    input logic rst,
    cv32e40p_perm_fault_detector_ft_if.slave bus
);
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    logic [3:0][CNT_W-1:0] alu_cnt_q, alu_cnt_d;
    logic [2:0][CNT_W-1:0] mult_cnt_q, mult_cnt_d;
    logic [3:0]            alu_flt_q, alu_flt_d;
    logic [2:0]            mult_flt_q, mult_flt_d;
    logic                  event_q, event_d;

    // Flagged replicas are frozen, so an unflagged counter is always below THR.
    function automatic logic [CNT_W-1:0] cnt_nxt(input logic [CNT_W-1:0] c, input logic upd, input logic mis);
        cnt_nxt = !upd ? c :
                  mis ? (c == THR ? THR : c + 1'b1) :
`ifdef FT_PERM_FAULT_DECAY_EN
                  (c == '0 ? c : c - 1'b1);
`else
                  c;
`endif
    endfunction

    always_comb begin
        alu_cnt_d  = alu_cnt_q;
        alu_flt_d  = alu_flt_q;
        mult_cnt_d = mult_cnt_q;
        mult_flt_d = mult_flt_q;
        for (int k = 0; k < 4; k++) begin
            alu_cnt_d[k] = bus.clear_i ? '0 :
                cnt_nxt(alu_cnt_q[k], bus.alu_valid_i & bus.alu_active_i[k] & ~alu_flt_q[k], bus.alu_mismatch_i[k]);
            alu_flt_d[k] = ~bus.clear_i & (alu_flt_q[k] | (alu_cnt_d[k] == THR));
        end
        for (int k = 0; k < 3; k++) begin
            mult_cnt_d[k] = bus.clear_i ? '0 :
                cnt_nxt(mult_cnt_q[k], bus.mult_valid_i & bus.mult_active_i[k] & ~mult_flt_q[k], bus.mult_mismatch_i[k]);
            mult_flt_d[k] = ~bus.clear_i & (mult_flt_q[k] | (mult_cnt_d[k] == THR));
        end
        // Clear forces every next flag low, so no event can fire on clear.
        event_d = |(alu_flt_d & ~alu_flt_q) | |(mult_flt_d & ~mult_flt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_cnt_q  <= '0;
            mult_cnt_q <= '0;
            alu_flt_q  <= '0;
            mult_flt_q <= '0;
            event_q    <= 1'b0;
        end else begin
            alu_cnt_q  <= alu_cnt_d;
            mult_cnt_q <= mult_cnt_d;
            alu_flt_q  <= alu_flt_d;
            mult_flt_q <= mult_flt_d;
            event_q    <= event_d;
        end
    end

    assign bus.permanent_faulty_alu_o  = alu_flt_q;
    assign bus.permanent_faulty_mult_o = mult_flt_q;
    assign bus.fault_event_o           = event_q;
    assign bus.alu_err_cnt_o           = alu_cnt_q;
endmodule

// File: tb/tb_cv32e40p_perm_fault_detector_ft.sv
// tb_cv32e40p_perm_fault_detector_ft: directed and random stimulus against a counting model of the fault detector.
module tb_cv32e40p_perm_fault_detector_ft;
    localparam int TH = 4;
    localparam int CW = $clog2(TH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cv32e40p_perm_fault_detector_ft_if #(.CNT_W(CW)) bus ();

    cv32e40p_perm_fault_detector_ft #(.THRESHOLD(TH)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_alu[4];
    int m_mult[3];
    logic [3:0] m_af;
    logic [2:0] m_mf;
    logic       m_ev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("perm_alu", 32'(bus.permanent_faulty_alu_o), 32'(m_af));
        check("perm_mult", 32'(bus.permanent_faulty_mult_o), 32'(m_mf));
        check("fault_event", 32'(bus.fault_event_o), 32'(m_ev));
        for (int k = 0; k < 4; k++)
            check($sformatf("alu_cnt%0d", k), 32'(bus.alu_err_cnt_o[k*CW +: CW]), 32'(m_alu[k]));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_alu[k] = 0;
        for (int k = 0; k < 3; k++) m_mult[k] = 0;
        m_af = '0;
        m_mf = '0;
        m_ev = 1'b0;
    endtask

    // One voted cycle: drive inputs, clock, advance the model by the behavioural rules, compare.
    task automatic step(input logic clr, input logic av, input logic [3:0] aa, input logic [3:0] am,
                        input logic mv, input logic [2:0] ma, input logic [2:0] mm);
        logic set;
        bus.clear_i = clr;
        bus.alu_valid_i = av;
        bus.alu_active_i = aa;
        bus.alu_mismatch_i = am;
        bus.mult_valid_i = mv;
        bus.mult_active_i = ma;
        bus.mult_mismatch_i = mm;
        @(posedge clk);
        set = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++)
                if (av && aa[k] && !m_af[k]) begin
                    if (am[k]) begin
                        m_alu[k] = (m_alu[k] + 1 > TH) ? TH : m_alu[k] + 1;
                        if (m_alu[k] == TH) begin m_af[k] = 1'b1; set = 1'b1; end
                    end
`ifdef FT_PERM_FAULT_DECAY_EN
                    else if (m_alu[k] > 0) m_alu[k]--;
`endif
                end
            for (int k = 0; k < 3; k++)
                if (mv && ma[k] && !m_mf[k]) begin
                    if (mm[k]) begin
                        m_mult[k] = (m_mult[k] + 1 > TH) ? TH : m_mult[k] + 1;
                        if (m_mult[k] == TH) begin m_mf[k] = 1'b1; set = 1'b1; end
                    end
`ifdef FT_PERM_FAULT_DECAY_EN
                    else if (m_mult[k] > 0) m_mult[k]--;
`endif
                end
        end
        m_ev = set;
        #1;
        check_model();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'b0, 3'($urandom), 3'($urandom));
    endtask

    initial begin
        int dec_exp[4];
`ifdef FT_PERM_FAULT_DECAY_EN
        dec_exp = '{1, 0, 1, 0};
`else
        dec_exp = '{1, 1, 2, 2};
`endif
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.clear_i = 1'($urandom);
            bus.alu_valid_i = 1'($urandom);
            bus.alu_active_i = 4'($urandom);
            bus.alu_mismatch_i = 4'($urandom);
            bus.mult_valid_i = 1'($urandom);
            bus.mult_active_i = 3'($urandom);
            bus.mult_mismatch_i = 3'($urandom);
            @(posedge clk);
        end
        #1;
        model_reset();
        check_model();
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'b0111, 4'b0010, 1'b0, 3'b000, 3'b000);
            check("alu1_flag", 32'(bus.permanent_faulty_alu_o), (i == 3) ? 32'h2 : 32'h0);
        end
        check("alu1_event", 32'(bus.fault_event_o), 32'h1);
        idle();
        check("alu1_event_drop", 32'(bus.fault_event_o), 32'h0);
        step(1'b0, 1'b1, 4'b0111, 4'b0010, 1'b0, 3'b000, 3'b000);
        check("alu1_sat", 32'(bus.alu_err_cnt_o[1*CW +: CW]), 32'(TH));

        step(1'b0, 1'b1, 4'b0111, 4'b1000, 1'b0, 3'b000, 3'b000);
        check("alu3_inactive", 32'(bus.alu_err_cnt_o[3*CW +: CW]), 32'h0);
        for (int i = 0; i < TH; i++) step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'b111, 3'b100);
        check("mult2_novalid", 32'(bus.permanent_faulty_mult_o), 32'h0);

        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'b000, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'b0001, (i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 3'b000, 3'b000);
            check($sformatf("decay_seq%0d", i), 32'(bus.alu_err_cnt_o[0 +: CW]), 32'(dec_exp[i]));
        end
        check("decay_noflag", 32'(bus.permanent_faulty_alu_o), 32'h0);

        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'b000, 3'b000);
        for (int i = 0; i < TH - 1; i++) step(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0, 3'b000, 3'b000);
        check("simul_flags", 32'(bus.permanent_faulty_alu_o), 32'h3);
        check("simul_event", 32'(bus.fault_event_o), 32'h1);
        idle();
        check("simul_event_drop", 32'(bus.fault_event_o), 32'h0);
        step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 3'b111, 3'b111);
        check("clear_flags", 32'(bus.permanent_faulty_alu_o), 32'h0);
        check("clear_cnt0", 32'(bus.alu_err_cnt_o[0 +: CW]), 32'h0);
        check("clear_event", 32'(bus.fault_event_o), 32'h0);

        for (int i = 0; i < TH; i++) step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 3'b111, 3'b111);
        check("mult_all", 32'(bus.permanent_faulty_mult_o), 32'h7);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
        check("mult_hold", 32'(bus.permanent_faulty_mult_o), 32'h7);
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'b000, 3'b000);
        check("mult_clear", 32'(bus.permanent_faulty_mult_o), 32'h0);

        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 99) == 0), 1'($urandom), 4'($urandom), 4'($urandom & $urandom),
                 1'($urandom), 3'($urandom), 3'($urandom & $urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
